// File: rtl/projectile_range_unit.sv
// projectile_range_unit
//   Iterative fixed-point range calculator: d = v^2 * sin(2*theta) / g.
//   sin() is a truncated Taylor series evaluated one term per cycle. The
//   multiply by 1/g uses an unsigned Q0.16 reciprocal.
// Ports:
//   clk, reset    - rising-edge clock, synchronous active-high reset
//   start         - request, only looked at in IDLE
//   v             - launch speed, unsigned integer
//   x             - launch angle in radians, unsigned Q(FRAC)
//   busy          - high in every state except IDLE
//   done          - one-cycle pulse while in DONE
//   final_result  - range, unsigned integer, held until the next DONE
//   sat           - final_result was clipped to all ones
//   err           - angle above X_MAX, final_result forced to 0
module projectile_range_unit #(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 12,
  parameter int N_TERMS = 8,
  parameter int X_MAX   = 6433,
  parameter int G_RECIP = 6681
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] final_result,
  output logic             sat,
  output logic             err
);

  // SW: term/sum width with headroom for the largest Taylor term (~5.2 at pi).
  // PW: Taylor products. MW: v^2 * sum. DW: product with the reciprocal.
  localparam int SW = WIDTH + 4;
  localparam int PW = 2 * SW;
  localparam int MW = 2 * WIDTH + SW + 1;
  localparam int DW = MW + 16;
  localparam logic [WIDTH-1:0] XMAX_W = WIDTH'(X_MAX);

  typedef enum logic [2:0] {S_IDLE, S_SQ, S_TERM, S_MUL, S_DIV, S_DONE} state_t;

  // Rounded Taylor ratio 2^FRAC / (2k(2k+1)), integer form of floor(a/d + 0.5).
  function automatic longint coef(input int k);
    longint d;
    d = longint'(2 * k * (2 * k + 1));
    return ((longint'(1) << (FRAC + 1)) + d) / (2 * d);
  endfunction

  logic signed [PW-1:0] ctab [16];
  for (genvar i = 0; i < 16; i++) begin : g_coef
    if (i == 0) begin : g_zero
      assign ctab[i] = '0;
    end else begin : g_val
      assign ctab[i] = PW'(coef(i));
    end
  end

  state_t state_q, state_n;

  logic [WIDTH-1:0]        v_q;
  logic                    bad_q;
  logic signed [SW-1:0]    y_q, y2_q, term_q, sum_q;
  logic [3:0]              k_q;
  logic [2*WIDTH-1:0]      vv_q;
  logic [MW-1:0]           p_q;

  // ---- datapath ----
  logic signed [SW-1:0]    y_init;
  logic signed [PW-1:0]    y_w, ysq, y2_w, t_w, t1, t2;
  logic signed [SW-1:0]    term_nx;
  logic [2*WIDTH-1:0]      vv_c;
  logic signed [MW-1:0]    vv_s, sum_s, prod;
  logic [MW-1:0]           p_nx;
  logic [DW-1:0]           r_full;
  logic                    sat_nx;
  logic [WIDTH-1:0]        r_nx;
  logic                    unused_bits;

  assign y_init  = SW'({x, 1'b0});
  assign y_w     = PW'(y_q);
  assign ysq     = (y_w * y_w) >>> FRAC;
  assign y2_w    = PW'(y2_q);
  assign t_w     = PW'(term_q);
  assign t1      = (t_w * y2_w) >>> FRAC;
  assign t2      = (t1 * ctab[k_q]) >>> FRAC;
  assign term_nx = -$signed(t2[SW-1:0]);

  assign vv_c    = {{WIDTH{1'b0}}, v_q} * {{WIDTH{1'b0}}, v_q};

  assign vv_s    = $signed(MW'(vv_q));
  assign sum_s   = MW'(sum_q);
  assign prod    = (vv_s * sum_s) >>> FRAC;
  // A negative series sum (truncation error near pi) means zero range.
  assign p_nx    = sum_q[SW-1] ? '0 : prod;

  assign r_full  = (DW'(p_q) * DW'(G_RECIP)) >> 16;
  assign sat_nx  = |r_full[DW-1:WIDTH];
  assign r_nx    = sat_nx ? '1 : r_full[WIDTH-1:0];

  assign unused_bits = ^{ysq[PW-1:SW], t2[PW-1:SW]};

  // ---- next state ----
  // An out-of-range angle still passes through SQ so the error result
  // lands one cycle after capture, same as the original controller.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_n = S_SQ;
      S_SQ: begin
        if (bad_q)             state_n = S_DONE;
        else if (N_TERMS == 1) state_n = S_MUL;
        else                   state_n = S_TERM;
      end
      S_TERM: if (k_q == 4'(N_TERMS - 1)) state_n = S_MUL;
      S_MUL:  state_n = S_DIV;
      S_DIV:  state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // ---- registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      final_result <= '0;
      sat          <= 1'b0;
      err          <= 1'b0;
      v_q          <= '0;
      bad_q        <= 1'b0;
      y_q          <= '0;
      y2_q         <= '0;
      term_q       <= '0;
      sum_q        <= '0;
      k_q          <= '0;
      vv_q         <= '0;
      p_q          <= '0;
    end else begin
      state_q <= state_n;
      busy    <= (state_n != S_IDLE);
      done    <= (state_n == S_DONE);
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            v_q    <= v;
            bad_q  <= (x > XMAX_W);
            y_q    <= y_init;
            term_q <= y_init;
            sum_q  <= y_init;
            k_q    <= 4'd1;
          end
        end
        S_SQ: begin
          y2_q <= ysq[SW-1:0];
          vv_q <= vv_c;
          if (bad_q) begin
            final_result <= '0;
            sat          <= 1'b0;
            err          <= 1'b1;
          end
        end
        S_TERM: begin
          term_q <= term_nx;
          sum_q  <= sum_q + term_nx;
          k_q    <= k_q + 4'd1;
        end
        S_MUL: p_q <= p_nx;
        S_DIV: begin
          final_result <= r_nx;
          sat          <= sat_nx;
          err          <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_projectile_range_unit.sv
module tb_projectile_range_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start;
  logic [15:0] v, x;
  logic [2:0]  busy, done, sat, err;
  logic [15:0] fr [3];

  int total = 0;
  int bad   = 0;

  int     c_ref [8] = '{0, 683, 205, 98, 57, 37, 26, 20};
  longint bv    [3] = '{100, 50, 300};
  longint bx    [3] = '{3217, 1000, 2000};

  always #5 clk = ~clk;

  projectile_range_unit #(.N_TERMS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start[0]), .v(v), .x(x),
    .busy(busy[0]), .done(done[0]), .final_result(fr[0]), .sat(sat[0]), .err(err[0]));
  projectile_range_unit #(.N_TERMS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start[1]), .v(v), .x(x),
    .busy(busy[1]), .done(done[1]), .final_result(fr[1]), .sat(sat[1]), .err(err[1]));
  projectile_range_unit #(.N_TERMS(8)) dut8 (
    .clk(clk), .reset(reset), .start(start[2]), .v(v), .x(x),
    .busy(busy[2]), .done(done[2]), .final_result(fr[2]), .sat(sat[2]), .err(err[2]));

  function automatic int nt_of(input int w);
    return (w == 0) ? 1 : (w == 1) ? 4 : 8;
  endfunction

  // Reference: range from the fixed-point rules, in plain 64-bit arithmetic.
  function automatic void model(input int nt, input longint vi, input longint xi,
                                output longint r, output logic s, output logic e);
    longint y, y2, term, sum, p;
    s = 1'b0;
    if (xi > 6433) begin
      r = 0; e = 1'b1;
      return;
    end
    e    = 1'b0;
    y    = 2 * xi;
    y2   = (y * y) >>> 12;
    term = y;
    sum  = y;
    for (int k = 1; k < nt; k++) begin
      term = -((((term * y2) >>> 12) * c_ref[k]) >>> 12);
      sum  = sum + term;
    end
    p = (sum < 0) ? 0 : ((vi * vi * sum) >>> 12);
    r = (p * 6681) >>> 16;
    if (r > 65535) begin
      r = 65535; s = 1'b1;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input int w, input longint vi, input longint xi);
    longint er;
    logic   es, ee;
    int     lat;
    model(nt_of(w), vi, xi, er, es, ee);
    @(negedge clk);
    v = 16'(vi); x = 16'(xi); start[w] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[w] = 1'b0;
    chk("busy_after_start", busy[w], 1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done[w]) begin
        lat = n;
        break;
      end
    end
    chk("latency", lat, ee ? 1 : nt_of(w) + 2);
    chk("result", fr[w], er);
    chk("sat", sat[w], es);
    chk("err", err[w], ee);
    @(posedge clk);
    @(negedge clk);
    chk("done_one_cycle", done[w], 0);
    chk("busy_back_idle", busy[w], 0);
    chk("result_held", fr[w], er);
  endtask

  initial begin
    int     idx;
    bit     seen;
    longint er;
    logic   es, ee;

    reset = 1'b1; start = '0; v = '0; x = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int w = 0; w < 3; w++) begin
      chk("rst_busy", busy[w], 0);
      chk("rst_done", done[w], 0);
      chk("rst_result", fr[w], 0);
      chk("rst_sat", sat[w], 0);
      chk("rst_err", err[w], 0);
    end

    // zero angle
    run_op(2, 10, 0);
    chk("zero_angle", fr[2], 0);
    // 45 degrees
    run_op(2, 100, 3217);
    chk("deg45_near_ideal", (fr[2] >= 16'd1017 && fr[2] <= 16'd1021), 1);
    // saturation
    run_op(2, 65535, 3217);
    chk("sat_value", fr[2], 65535);
    chk("sat_flag", sat[2], 1);
    // range error then recovery
    run_op(2, 50, 6434);
    run_op(2, 50, 3217);
    chk("err_cleared", err[2], 0);
    chk("v50_near_ideal", (fr[2] >= 16'd253 && fr[2] <= 16'd257), 1);
    // boundary angle
    run_op(2, 1000, 6433);

    // reset in the middle of an op
    @(negedge clk);
    v = 16'd100; x = 16'd3217; start[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[2] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", busy[2], 0);
    chk("midrst_done", done[2], 0);
    chk("midrst_result", fr[2], 0);
    chk("midrst_sat", sat[2], 0);
    chk("midrst_err", err[2], 0);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      if (done[2]) seen = 1'b1;
    end
    chk("midrst_no_done", seen, 0);
    run_op(2, 100, 3217);

    // start held high for three back-to-back ops
    @(negedge clk);
    v = 16'(bv[0]); x = 16'(bx[0]); start[2] = 1'b1;
    idx = 0;
    for (int c = 0; c < 60 && idx < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done[2]) begin
        model(8, bv[idx], bx[idx], er, es, ee);
        chk("b2b_cycle", c, idx * 12 + 10);
        chk("b2b_result", fr[2], er);
        chk("b2b_sat", sat[2], es);
        idx++;
        if (idx < 3) begin
          v = 16'(bv[idx]); x = 16'(bx[idx]);
        end else begin
          start[2] = 1'b0;
        end
      end
    end
    chk("b2b_count", idx, 3);

    // random sweep on all three term counts
    for (int w = 0; w < 3; w++) begin
      run_op(w, 100, 3217);
      run_op(w, 77, 6434);
      for (int n = 0; n < 8; n++)
        run_op(w, longint'($urandom_range(0, 65535)), longint'($urandom_range(0, 7000)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
